// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci index search.
package fib_pkg;

    typedef enum logic {
        IDLE,
        SEARCH
    } state_t;

    // Largest Fibonacci index whose term still fits in 128 bits.
    localparam int FIB_MAX_IDX_W128 = 186;

endpackage

// File: rtl/fib_seq_core.sv
// Fibonacci term generator: holds the a/b pair and the index of b.
module fib_seq_core
    import fib_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             advance,
    output logic [WIDTH:0]   b,
    output logic [IDX_W-1:0] idx
);

    logic [WIDTH-1:0] a;

    // NOTE: every register here, datapath included, is cleared by reset so a
    // search aborted by reset leaves no stale term behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a   <= '0;
            b   <= '0;
            idx <= '0;
        end else if (load) begin
            a   <= '0;
            b   <= (WIDTH+1)'(1);
            idx <= IDX_W'(1);
        end else if (advance) begin
            // advance only happens while b < tgt, so b fits in WIDTH bits here
            a   <= b[WIDTH-1:0];
            b   <= {1'b0, a} + b;
            idx <= idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/fib_index.sv
// Fibonacci index search: reports whether value is F(k) and its index k.
// Optional FIB_INDEX_START_ERR_EN adds a start_err pulse for starts seen while busy.
module fib_index
    import fib_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
`ifdef FIB_INDEX_START_ERR_EN
    output logic             start_err,
`endif
    output logic             busy,
    output logic             done,
    output logic             is_fib,
    output logic [IDX_W-1:0] index
);

    state_t           state;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH:0]   b;
    logic [IDX_W-1:0] idx;
    logic             load;
    logic             advance;
    logic             tgt_zero;
    logic             hit;
    logic             over;

    assign tgt_zero = (tgt == '0);
    assign hit      = (b == {1'b0, tgt});
    assign over     = (b > {1'b0, tgt});
    assign load     = (state == IDLE) && start;
    assign advance  = (state == SEARCH) && !tgt_zero && !hit && !over;

    fib_seq_core #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .advance (advance),
        .b       (b),
        .idx     (idx)
    );

    // NOTE: non-blocking assignments throughout so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            tgt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            is_fib <= 1'b0;
            index  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tgt   <= value;
                        busy  <= 1'b1;
                        state <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (tgt_zero || hit || over) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (tgt_zero) begin
                            is_fib <= 1'b1;
                            index  <= '0;
                        end else if (hit) begin
                            is_fib <= 1'b1;
                            index  <= idx;
                        end else begin
                            is_fib <= 1'b0;
                            index  <= idx - IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIB_INDEX_START_ERR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) start_err <= 1'b0;
        else      start_err <= start && busy;
    end
`endif

endmodule
